// File: rtl/sumador_visual_param.sv
// Add/subtract unit with sequential double-dabble BCD conversion and a multiplexed common-anode 7-segment driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero magnitude digits.
module sumador_visual_param #(
  parameter int WIDTH       = 8,
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [0:6]       SSeg,
  output logic [NDIG-1:0]  an
);

  // state  | meaning
  // S_IDLE | waiting for start, operands sampled here
  // S_CONV | double-dabble shifting, WIDTH+1 steps
  // S_DONE | display register just updated, done pulse
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int     BCD_DIG = (WIDTH + 3) / 3;
  localparam int     BCD_W   = 4 * BCD_DIG;
  localparam int     MAG_W   = 4 * (NDIG - 1);
  localparam int     STEP_W  = $clog2(WIDTH + 2);
  localparam int     RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int     DW      = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam longint LIMIT   = longint'(10 ** (NDIG - 1)) - 1;

  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  logic [1:0]        state;
  logic [WIDTH:0]    bin;
  logic [BCD_W-1:0]  bcd;
  logic [STEP_W-1:0] steps;
  logic              neg_pend;
  logic              ovf_pend;
  logic [MAG_W-1:0]  disp_mag;
  logic              disp_neg;
  logic [RW-1:0]     refresh_cnt;
  logic [DW-1:0]     dig_idx;

  logic [WIDTH:0]    res;
  logic              res_neg;
  logic [WIDTH:0]    mag;
  logic              mag_ovf;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_shift;
  logic [MAG_W-1:0]  digits_next;

  always_comb begin
    res     = Sel ? ({1'b0, A} - {1'b0, B}) : ({1'b0, A} + {1'b0, B});
    res_neg = Sel & res[WIDTH];
    mag     = res_neg ? -res : res;
    mag_ovf = longint'(mag) > LIMIT;
  end

  // The shifted-out MSB of the top nibble is always zero because BCD_DIG covers 2^(WIDTH+1)-1.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_shift = BCD_W'({bcd_adj, bin[WIDTH]});
  end

  for (genvar g = 0; g < NDIG - 1; g++) begin : g_dig
    if (g < BCD_DIG) begin : g_bcd
      assign digits_next[4*g +: 4] = bcd_shift[4*g +: 4];
    end else begin : g_pad
      assign digits_next[4*g +: 4] = 4'd0;
    end
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bin      <= '0;
      bcd      <= '0;
      steps    <= '0;
      neg_pend <= 1'b0;
      ovf_pend <= 1'b0;
      disp_mag <= '0;
      disp_neg <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bin      <= mag;
            bcd      <= '0;
            steps    <= STEP_W'(WIDTH + 1);
            neg_pend <= res_neg;
            ovf_pend <= mag_ovf;
            state    <= S_CONV;
          end
        end
        S_CONV: begin
          bcd   <= bcd_shift;
          bin   <= {bin[WIDTH-1:0], 1'b0};
          steps <= steps - 1'b1;
          if (steps == STEP_W'(1)) begin
            disp_mag <= digits_next;
            disp_neg <= neg_pend;
            ovf      <= ovf_pend;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_CONV);
  assign done = (state == S_DONE);

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      dig_idx     <= '0;
    end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      dig_idx     <= (dig_idx == DW'(NDIG - 1)) ? '0 : dig_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    an          = '1;
    an[dig_idx] = 1'b0;
  end

  function automatic logic [0:6] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_BLANK;
    endcase
  endfunction

  logic [NDIG-2:0] lead_zero;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    lead_zero = '0;
    for (int i = NDIG - 2; i >= 1; i--) begin
      seen         = seen | (disp_mag[4*i +: 4] != 4'd0);
      lead_zero[i] = ~seen;
    end
  end
`else
  assign lead_zero = '0;
`endif

  logic [3:0] cur_digit;
  logic       cur_lz;

  always_comb begin
    cur_digit = 4'd0;
    cur_lz    = 1'b0;
    for (int i = 0; i < NDIG - 1; i++) begin
      if (dig_idx == DW'(i)) begin
        cur_digit = disp_mag[4*i +: 4];
        cur_lz    = lead_zero[i];
      end
    end
    if (ovf)                             SSeg = SEG_DASH;
    else if (dig_idx == DW'(NDIG - 1))   SSeg = disp_neg ? SEG_DASH : SEG_BLANK;
    else if (cur_lz)                     SSeg = SEG_BLANK;
    else                                 SSeg = glyph(cur_digit);
  end

endmodule

// File: tb/tb_sumador_visual_param.sv
// Bench for sumador_visual_param: integer reference model checked every cycle, plus literal display checks.
// Honours LEADING_ZERO_BLANK_EN the same way as the design.
module tb_sumador_visual_param;
  localparam int WIDTH = 8;
  localparam int NDIG  = 4;
  localparam int RD    = 4;

  localparam logic [0:6] G_BLANK = 7'b1111111;
  localparam logic [0:6] G_DASH  = 7'b1111110;
  localparam logic [0:6] G_ZERO  = 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [0:6] G_LZ = G_BLANK;
`else
  localparam logic [0:6] G_LZ = G_ZERO;
`endif

  logic       clk2  = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] A     = '0;
  logic [7:0] B     = '0;
  logic       Sel   = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, ovf;
  logic [0:6] SSeg;
  logic [3:0] an;
  logic       busy3, done3, ovf3;
  logic [0:6] sseg3;
  logic [2:0] an3;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  logic [0:6] cap [NDIG];

  always #5 clk2 = ~clk2;

  sumador_visual_param #(.WIDTH(WIDTH), .NDIG(NDIG), .REFRESH_DIV(RD)) dut (
    .clk2(clk2), .rst_n(rst_n), .A(A), .B(B), .Sel(Sel), .start(start),
    .busy(busy), .done(done), .ovf(ovf), .SSeg(SSeg), .an(an)
  );

  sumador_visual_param #(.WIDTH(WIDTH), .NDIG(3), .REFRESH_DIV(RD)) dut3 (
    .clk2(clk2), .rst_n(rst_n), .A(A), .B(B), .Sel(Sel), .start(start),
    .busy(busy3), .done(done3), .ovf(ovf3), .SSeg(sseg3), .an(an3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [0:6] glyph(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return G_BLANK;
    endcase
  endfunction

  // Reference model: phase 0 idle, 1 converting, 2 done pulse; m_cyc counts edges since reset.
  int m_cyc   = 0;
  int m_phase = 0;
  int m_left  = 0;
  int m_pend  = 0;
  int m_val   = 0;
  bit m_ovf   = 1'b0;

  always @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_phase = 0; m_left = 0; m_val = 0; m_ovf = 1'b0;
    end else begin
      m_cyc++;
      case (m_phase)
        0: if (start) begin
             m_pend  = Sel ? int'(A) - int'(B) : int'(A) + int'(B);
             m_left  = WIDTH + 1;
             m_phase = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_val   = m_pend;
               m_ovf   = ((m_pend < 0) ? -m_pend : m_pend) > 10 ** (NDIG - 1) - 1;
               m_phase = 2;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  function automatic logic [0:6] exp_seg(input int idx);
    int mag;
    if (m_ovf) return G_DASH;
    if (idx == NDIG - 1) return (m_val < 0) ? G_DASH : G_BLANK;
    mag = (m_val < 0) ? -m_val : m_val;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && mag < 10 ** idx) return G_BLANK;
`endif
    return glyph((mag / (10 ** idx)) % 10);
  endfunction

  always @(negedge clk2) begin
    if (chk_en) begin
      int idx;
      logic [3:0] e_an;
      idx       = (m_cyc / RD) % NDIG;
      e_an      = '1;
      e_an[idx] = 1'b0;
      check("an", an, e_an);
      check("seg", SSeg, exp_seg(idx));
      check("busy", busy, m_phase == 1);
      check("done", done, m_phase == 2);
      check("ovf", ovf, m_ovf);
    end
  end

  task automatic op(input int a, input int b, input bit s);
    @(posedge clk2); #2;
    A = 8'(a); B = 8'(b); Sel = s; start = 1'b1;
    @(posedge clk2); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int done_edge, output int busy_cnt);
    done_edge = -1;
    busy_cnt  = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk2);
      if (busy) busy_cnt++;
      if (done) begin
        done_edge = j - 1;
        break;
      end
    end
    if (done_edge < 0) begin
      n_checks++;
      $display("FAIL done_timeout: no done within 40 cycles, expected one");
    end
  endtask

  task automatic capture();
    for (int k = 0; k < NDIG * RD; k++) begin
      @(negedge clk2);
      for (int i = 0; i < NDIG; i++) if (an[i] == 1'b0) cap[i] = SSeg;
    end
  endtask

  task automatic check_disp(input string name, input logic [0:6] d3, input logic [0:6] d2,
                            input logic [0:6] d1, input logic [0:6] d0);
    capture();
    check({name, "_d3"}, cap[3], d3);
    check({name, "_d2"}, cap[2], d2);
    check({name, "_d1"}, cap[1], d1);
    check({name, "_d0"}, cap[0], d0);
  endtask

  initial begin
    int de, bc, nd, bad;
    logic [3:0] an_seq [5];
    an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    #1 rst_n = 1'b0;
    #3;
    check("rst_an", an, 4'b1110);
    check("rst_seg", SSeg, G_ZERO);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    chk_en = 1'b1;
    @(posedge clk2); #2 rst_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk2);
      check("an_rotate", an, an_seq[k / 4]);
    end

    op(7, 1, 0);
    wait_done(de, bc);
    check("t2_busy_cycles", bc, 9);
    check("t2_done_edge", de, 9);
    check_disp("t2", G_BLANK, G_LZ, G_LZ, 7'b0000000);

    op(2, 5, 1);
    wait_done(de, bc);
    check("t3_ovf", ovf, 1'b0);
    check_disp("t3a", G_DASH, G_LZ, G_LZ, 7'b0000110);
    op(5, 3, 1);
    wait_done(de, bc);
    check_disp("t3b", G_BLANK, G_LZ, G_LZ, 7'b0010010);
    check("t3_ovf3", ovf3, 1'b0);

    op(255, 255, 0);
    wait_done(de, bc);
    check("t4_ovf", ovf, 1'b0);
    check("t4_ovf3", ovf3, 1'b1);
    bad = 0;
    for (int k = 0; k < 3 * RD; k++) begin
      @(negedge clk2);
      if (sseg3 !== G_DASH) bad++;
    end
    check("t4_dut3_dash_errs", bad, 0);
    check_disp("t4a", G_BLANK, 7'b0100100, 7'b1001111, G_ZERO);
    op(0, 255, 1);
    wait_done(de, bc);
    check_disp("t4b", G_DASH, 7'b0010010, 7'b0100100, 7'b0100100);

    // Extra start pulse sampled at the third conversion edge must be ignored.
    op(9, 4, 0);
    repeat (2) @(posedge clk2);
    #2 start = 1'b1;
    @(posedge clk2); #2 start = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk2);
      if (done) nd++;
    end
    check("t5_done_count", nd, 1);
    check_disp("t5", G_BLANK, G_LZ, 7'b1001111, 7'b0000110);

    op(100, 50, 0);
    repeat (4) @(posedge clk2);
    #1 check("t5_busy_before_rst", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_an", an, 4'b1110);
    check("t5_rst_seg", SSeg, G_ZERO);
    @(posedge clk2); #2 rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk2);
      if (done) nd++;
    end
    check("t5_no_done_after_rst", nd, 0);
    check_disp("t5r", G_BLANK, G_LZ, G_LZ, G_ZERO);

    for (int n = 0; n < 25; n++) begin
      op($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      wait_done(de, bc);
      check("rand_done_edge", de, 9);
      repeat ($urandom_range(0, 3)) @(posedge clk2);
    end

    @(posedge clk2); #2;
    A = 8'($urandom_range(0, 255)); B = 8'($urandom_range(0, 255)); Sel = 1'b1; start = 1'b1;
    repeat (35) @(posedge clk2);
    #2 start = 1'b0;
    repeat (25) @(posedge clk2);

    @(negedge clk2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
